clock_display_scan: RTL and testbench

- Consumer side of the 24-hour time counter: takes binary hrs/mins/secs and drives a 6-digit multiplexed seven-segment display (HH MM SS).
- Snapshots the time once per scan frame so the display never shows a torn value. Converts each field to two BCD digits and scans one digit per prescaler tick.
- Sits between the time counter and the board's segment/anode pins.

---
 rtl/clock_display_scan.sv | 135 +++++++++++++
 tb/tb_clock_display_scan.sv | 130 +++++++++++++
 2 files changed

// File: rtl/clock_display_scan.sv
// Six-digit HH MM SS multiplexed seven-segment scanner with per-frame time snapshot.
// Optional macro CLOCK_DISPLAY_COLON_BLINK_EN lights dp on the HH.MM.SS separators on even seconds.
module clock_display_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] hrs,
  input  logic [5:0] mins,
  input  logic [5:0] secs,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int            CW       = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] PRE_LAST = CW'(SCAN_DIV - 1);
  localparam logic [5:0]    AN_OFF   = SEG_ACTIVE_LOW ? 6'b111111 : 6'b000000;
  localparam logic [6:0]    SEG_OFF  = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
  localparam logic          DP_OFF   = SEG_ACTIVE_LOW;
  localparam logic [6:0]    SEG_DASH = 7'b0111111;

  logic [CW-1:0] prescaler;
  logic [2:0]    idx;
  logic [5:0]    snap_hrs, snap_mins, snap_secs;
  logic          started;
  logic          tick;

  logic [3:0]    digit;
  logic          dash;
  logic [6:0]    code_low;
  logic [5:0]    an_hot;
  logic [5:0]    an_nxt;
  logic [6:0]    seg_nxt;

  function automatic logic [3:0] tens_of(input logic [5:0] v);
    if (v >= 6'd60)      return 4'd6;
    else if (v >= 6'd50) return 4'd5;
    else if (v >= 6'd40) return 4'd4;
    else if (v >= 6'd30) return 4'd3;
    else if (v >= 6'd20) return 4'd2;
    else if (v >= 6'd10) return 4'd1;
    else                 return 4'd0;
  endfunction

  // v - 10*tens, with 10*t built as 8*t + 2*t
  function automatic logic [3:0] ones_of(input logic [5:0] v);
    logic [5:0] t6;
    t6 = {2'b00, tens_of(v)};
    return 4'(v - ((t6 << 3) + (t6 << 1)));
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_DASH;
    endcase
  endfunction

  assign tick = (prescaler == PRE_LAST);

  always_comb begin
    digit = 4'd0;
    dash  = 1'b0;
    case (idx)
      3'd0: begin digit = ones_of(snap_secs); dash = (snap_secs > 6'd59); end
      3'd1: begin digit = tens_of(snap_secs); dash = (snap_secs > 6'd59); end
      3'd2: begin digit = ones_of(snap_mins); dash = (snap_mins > 6'd59); end
      3'd3: begin digit = tens_of(snap_mins); dash = (snap_mins > 6'd59); end
      3'd4: begin digit = ones_of(snap_hrs);  dash = (snap_hrs  > 6'd23); end
      3'd5: begin digit = tens_of(snap_hrs);  dash = (snap_hrs  > 6'd23); end
      default: begin digit = 4'd0; dash = 1'b1; end
    endcase
  end

  assign code_low = dash ? SEG_DASH : seg_code(digit);
  assign an_hot   = 6'b000001 << idx;
  assign an_nxt   = SEG_ACTIVE_LOW ? ~an_hot : an_hot;
  assign seg_nxt  = SEG_ACTIVE_LOW ? code_low : ~code_low;

  // started keeps the display dark until the first snapshot exists
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler   <= '0;
      idx         <= 3'd5;
      snap_hrs    <= 6'd0;
      snap_mins   <= 6'd0;
      snap_secs   <= 6'd0;
      started     <= 1'b0;
      frame_start <= 1'b0;
      an          <= AN_OFF;
      seg         <= SEG_OFF;
    end else begin
      prescaler   <= tick ? '0 : prescaler + CW'(1);
      frame_start <= tick && (idx == 3'd5);
      if (tick) begin
        if (idx == 3'd5) begin
          idx       <= 3'd0;
          snap_hrs  <= hrs;
          snap_mins <= mins;
          snap_secs <= secs;
          started   <= 1'b1;
        end else begin
          idx <= idx + 3'd1;
        end
      end
      an  <= started ? an_nxt : AN_OFF;
      seg <= started ? seg_nxt : SEG_OFF;
    end
  end

`ifdef CLOCK_DISPLAY_COLON_BLINK_EN
  logic dp_on;
  assign dp_on = ~snap_secs[0] && ((idx == 3'd2) || (idx == 3'd4));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dp <= DP_OFF;
    else      dp <= (started && dp_on) ? ~DP_OFF : DP_OFF;
  end
`else
  assign dp = DP_OFF;
`endif

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed bench for clock_display_scan with SCAN_DIV=4, active-low outputs.
module tb_clock_display_scan;

  localparam int SD = 4;
`ifdef CLOCK_DISPLAY_COLON_BLINK_EN
  localparam bit COLON_EN = 1'b1;
`else
  localparam bit COLON_EN = 1'b0;
`endif

  localparam logic [6:0] C0 = 7'b1000000;
  localparam logic [6:0] C1 = 7'b1111001;
  localparam logic [6:0] C2 = 7'b0100100;
  localparam logic [6:0] C3 = 7'b0110000;
  localparam logic [6:0] C4 = 7'b0011001;
  localparam logic [6:0] C5 = 7'b0010010;
  localparam logic [6:0] C7 = 7'b1111000;
  localparam logic [6:0] C8 = 7'b0000000;
  localparam logic [6:0] C9 = 7'b0010000;
  localparam logic [6:0] DS = 7'b0111111;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] hrs = 6'd0, mins = 6'd0, secs = 6'd0;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  int checks = 0;
  int errors = 0;

  clock_display_scan #(.SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .hrs(hrs), .mins(mins), .secs(secs),
    .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // s is {idx5,...,idx0}; frame runs from the cycle after a snapshot up to the next snapshot
  task automatic check_frame(input string tag, input logic [5:0][6:0] s, input bit colon);
    logic [5:0] ea;
    logic       ed;
    logic       ef;
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < SD; j++) begin
        cyc();
        ea = ~(6'b000001 << i);
        ed = 1'b1 ^ (COLON_EN & colon & ((i == 2) || (i == 4)));
        ef = (i == 5) && (j == SD - 1);
        chk({tag, "/an"}, {1'b0, an}, {1'b0, ea});
        chk({tag, "/seg"}, seg, s[i]);
        chk({tag, "/dp"}, {6'b0, dp}, {6'b0, ed});
        chk({tag, "/fs"}, {6'b0, frame_start}, {6'b0, ef});
      end
    end
  endtask

  task automatic check_release(input string tag);
    for (int k = 1; k <= SD; k++) begin
      cyc();
      chk({tag, "/fs"}, {6'b0, frame_start}, {6'b0, (k == SD)});
      chk({tag, "/an"}, {1'b0, an}, 7'b0111111);
      chk({tag, "/seg"}, seg, 7'b1111111);
    end
  endtask

  initial begin
    hrs = 6'd23; mins = 6'd59; secs = 6'd58;
    rst = 1'b0;
    repeat (3) cyc();
    chk("rst_an", {1'b0, an}, 7'b0111111);
    chk("rst_seg", seg, 7'b1111111);
    chk("rst_dp", {6'b0, dp}, 7'd1);
    chk("rst_fs", {6'b0, frame_start}, 7'd0);

    @(negedge clk);
    rst = 1'b1;
    check_release("release");

    check_frame("t235958", {C2, C3, C5, C9, C5, C8}, 1'b1);
    hrs = 6'd12; mins = 6'd34; secs = 6'd10;
    check_frame("wrap", {C2, C3, C5, C9, C5, C8}, 1'b1);

    // inputs change right after the snapshot; the frame must keep the old time
    hrs = 6'd7; mins = 6'd8; secs = 6'd11;
    check_frame("tear_old", {C1, C2, C3, C4, C1, C0}, 1'b1);
    hrs = 6'd24; mins = 6'd5; secs = 6'd7;
    check_frame("tear_new", {C0, C7, C0, C8, C1, C1}, 1'b0);

    hrs = 6'd0; mins = 6'd60; secs = 6'd63;
    check_frame("range_hrs", {DS, DS, C0, C5, C0, C7}, 1'b0);
    hrs = 6'd12; mins = 6'd34; secs = 6'd20;
    check_frame("range_ms", {C0, C0, DS, DS, DS, DS}, 1'b0);
    secs = 6'd21;
    check_frame("colon_even", {C1, C2, C3, C4, C2, C0}, 1'b1);

    repeat (13) cyc();
    chk("pre_rst_an", {1'b0, an}, 7'b0110111);
    #2;
    rst = 1'b0;
    #1;
    chk("async_an", {1'b0, an}, 7'b0111111);
    chk("async_seg", seg, 7'b1111111);
    chk("async_dp", {6'b0, dp}, 7'd1);
    chk("async_fs", {6'b0, frame_start}, 7'd0);
    repeat (2) cyc();
    @(negedge clk);
    rst = 1'b1;
    check_release("rerelease");
    check_frame("colon_odd", {C1, C2, C3, C4, C2, C1}, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
